// File: rtl/ift_pkg.sv
// Shared types and helpers for the IF-T fetch-response queue.
// Entry structs are sized for the widest supported configuration (PC_W <= 64, FETCH_W <= 8).
package ift_pkg;

  localparam int unsigned EXCODE_W   = 6;
  localparam int unsigned PC_MAX_W   = 64;
  localparam int unsigned FETCH_MAX  = 8;
  localparam int unsigned INST_MAX_W = 32 * FETCH_MAX;

  typedef struct packed {
    logic [PC_MAX_W-1:0] pc;
    logic                req;
    logic [EXCODE_W-1:0] excode;
  } pend_entry_t;

  typedef struct packed {
    logic [PC_MAX_W-1:0]   pc;
    logic [INST_MAX_W-1:0] inst;
    logic [FETCH_MAX-1:0]  mask;
    logic [EXCODE_W-1:0]   excode;
  } q_entry_t;

  // Lane k is valid iff k >= starting lane (pc[4:2] reduced to the group size) and k < fetch_w.
  function automatic logic [FETCH_MAX-1:0] mask_gen(input logic [2:0] pc_lane,
                                                    input int unsigned fetch_w);
    logic [FETCH_MAX-1:0] m;
    int unsigned          lane;
    lane = 32'(pc_lane) & (fetch_w - 1);
    m    = '0;
    for (int unsigned k = 0; k < FETCH_MAX; k++) begin
      m[k] = (k < fetch_w) && (k >= lane);
    end
    return m;
  endfunction

endpackage

// File: rtl/ift_sync_fifo.sv
// Width/depth-parametrised synchronous FIFO with synchronous clear.
// Clear has priority; push on a full FIFO is accepted only alongside a pop.
module ift_sync_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ptr_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= ptr_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/ift_resp_queue.sv
// IF-T fetch-response stage: in-order fetch tracking, flush cancel counting, credit-throttled output queue.
// Define IFT_RESP_CHECK_EN to build the sticky protocol checker driving error_o.
module ift_resp_queue
  import ift_pkg::*;
#(
  parameter int unsigned FETCH_W = 2,
  parameter int unsigned MAX_OUT = 2,
  parameter int unsigned QDEPTH  = 4,
  parameter int unsigned PC_W    = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush_i,
  input  logic                         fetch_fire_i,
  input  logic                         fetch_req_i,
  input  logic [PC_W-1:0]              fetch_pc_i,
  input  logic [EXCODE_W-1:0]          fetch_excode_i,
  output logic                         fetch_allow_o,
  input  logic                         icache_data_ok_i,
  input  logic [32*FETCH_W-1:0]        icache_rdata_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [PC_W-1:0]              out_pc_o,
  output logic [32*FETCH_W-1:0]        out_inst_o,
  output logic [FETCH_W-1:0]           out_mask_o,
  output logic [EXCODE_W-1:0]          out_excode_o,
  output logic [$clog2(MAX_OUT+1)-1:0] pend_cnt_o,
  output logic                         error_o
);

  localparam int unsigned CC_W  = $clog2(MAX_OUT + 1);
  localparam int unsigned QC_W  = $clog2(QDEPTH + 1);
  localparam int unsigned SUM_W = CC_W + 2;

  pend_entry_t     pend_in;
  pend_entry_t     pend_head;
  logic            pend_push;
  logic            pend_pop;
  logic            pend_empty;
  logic            pend_full;
  logic [CC_W-1:0] pend_count;
  logic [CC_W-1:0] pend_req_cnt;

  q_entry_t        q_in;
  q_entry_t        q_head;
  logic            q_push;
  logic            q_pop;
  logic            q_empty;
  logic            q_full;
  logic [QC_W-1:0] q_count;

  logic [CC_W-1:0]  cc;
  logic [CC_W-1:0]  cc_next;
  logic [SUM_W-1:0] cc_sum;
  logic [SUM_W-1:0] cc_flush;
  logic             cc_ovf;
  logic             cc_zero;
  logic             head_req;
  logic             head_exc;
  logic             data_take;
  logic             exc_pop;
  logic             exc_bypass;

  ift_sync_fifo #(.WIDTH($bits(pend_entry_t)), .DEPTH(MAX_OUT)) u_pend (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush_i),
    .push      (pend_push),
    .push_data (pend_in),
    .pop       (pend_pop),
    .head      (pend_head),
    .empty     (pend_empty),
    .full      (pend_full),
    .count     (pend_count)
  );

  ift_sync_fifo #(.WIDTH($bits(q_entry_t)), .DEPTH(QDEPTH)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .clear     (flush_i),
    .push      (q_push),
    .push_data (q_in),
    .pop       (q_pop),
    .head      (q_head),
    .empty     (q_empty),
    .full      (q_full),
    .count     (q_count)
  );

  // Response matching; an exception-only fire with nothing ahead of it goes straight to the queue.
  always_comb begin
    cc_zero    = (cc == '0);
    head_req   = !pend_empty && pend_head.req;
    head_exc   = !pend_empty && !pend_head.req;
    data_take  = icache_data_ok_i && cc_zero && head_req;
    exc_pop    = cc_zero && head_exc;
    exc_bypass = fetch_fire_i && !fetch_req_i && pend_empty && cc_zero;

    pend_push      = fetch_fire_i && !exc_bypass;
    pend_pop       = data_take || exc_pop;
    pend_in.pc     = PC_MAX_W'(fetch_pc_i);
    pend_in.req    = fetch_req_i;
    pend_in.excode = fetch_excode_i;

    q_push      = data_take || exc_pop || exc_bypass;
    q_in.pc     = exc_bypass ? PC_MAX_W'(fetch_pc_i) : pend_head.pc;
    q_in.excode = exc_bypass ? fetch_excode_i : pend_head.excode;
    q_in.inst   = data_take ? INST_MAX_W'(icache_rdata_i) : '0;
    q_in.mask   = mask_gen(q_in.pc[4:2], FETCH_W);
  end

  // Flush converts every live request (plus a coincident one) into a response still to be dropped.
  always_comb begin
    cc_sum   = SUM_W'(cc) + SUM_W'(pend_req_cnt) + SUM_W'(fetch_fire_i && fetch_req_i);
    cc_flush = cc_sum - SUM_W'(icache_data_ok_i && (cc_sum != '0));
    cc_ovf   = (cc_flush > SUM_W'(MAX_OUT));
    cc_next  = cc;
    if (flush_i) begin
      cc_next = cc_ovf ? CC_W'(MAX_OUT) : CC_W'(cc_flush);
    end else if (icache_data_ok_i && !cc_zero) begin
      cc_next = cc - CC_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cc           <= '0;
      pend_req_cnt <= '0;
    end else begin
      cc <= cc_next;
      if (flush_i) pend_req_cnt <= '0;
      else pend_req_cnt <= pend_req_cnt + CC_W'(pend_push && fetch_req_i) - CC_W'(data_take);
    end
  end

  assign fetch_allow_o = !rst && !flush_i
                         && ((32'(pend_count) + 32'(cc)) < MAX_OUT)
                         && ((32'(pend_count) + 32'(q_count)) < QDEPTH);

  assign q_pop        = out_valid_o && out_ready_i;
  assign out_valid_o  = !q_empty;
  assign out_pc_o     = q_head.pc[PC_W-1:0];
  assign out_inst_o   = q_head.inst[32*FETCH_W-1:0];
  assign out_mask_o   = q_head.mask[FETCH_W-1:0];
  assign out_excode_o = q_head.excode;
  assign pend_cnt_o   = pend_count + cc;

`ifdef IFT_RESP_CHECK_EN
  logic err_event;

  assign err_event = (icache_data_ok_i && cc_zero && !head_req)
                     || (fetch_fire_i && !fetch_allow_o)
                     || (flush_i && cc_ovf)
                     || (q_push && q_full);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) error_o <= 1'b0;
    else if (err_event) error_o <= 1'b1;
  end
`else
  assign error_o = 1'b0;
`endif

  logic unused_bits_c;
  assign unused_bits_c = ^{q_head, pend_full, q_full, cc_ovf};

endmodule

// File: tb/tb_ift_resp_queue.sv
// Directed self-checking bench for ift_resp_queue (FETCH_W=2, MAX_OUT=2, QDEPTH=4, PC_W=32).
module tb_ift_resp_queue;

  localparam logic ERR_EXP =
`ifdef IFT_RESP_CHECK_EN
    1'b1;
`else
    1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        fire;
  logic        req;
  logic [31:0] pc;
  logic [5:0]  excode;
  logic        allow;
  logic        data_ok;
  logic [63:0] rdata;
  logic        out_valid;
  logic        ready;
  logic [31:0] out_pc;
  logic [63:0] out_inst;
  logic [1:0]  out_mask;
  logic [5:0]  out_excode;
  logic [1:0]  pend_cnt;
  logic        error;

  int n_checks = 0;
  int n_fail   = 0;

  ift_resp_queue #(.FETCH_W(2), .MAX_OUT(2), .QDEPTH(4), .PC_W(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .flush_i          (flush),
    .fetch_fire_i     (fire),
    .fetch_req_i      (req),
    .fetch_pc_i       (pc),
    .fetch_excode_i   (excode),
    .fetch_allow_o    (allow),
    .icache_data_ok_i (data_ok),
    .icache_rdata_i   (rdata),
    .out_valid_o      (out_valid),
    .out_ready_i      (ready),
    .out_pc_o         (out_pc),
    .out_inst_o       (out_inst),
    .out_mask_o       (out_mask),
    .out_excode_o     (out_excode),
    .pend_cnt_o       (pend_cnt),
    .error_o          (error)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; flush = 1'b0; fire = 1'b0; req = 1'b0; pc = '0; excode = '0;
    data_ok = 1'b0; rdata = '0; ready = 1'b1;
    #1;
    chk("rst_allow", 64'(allow), 64'd0);
    chk("rst_valid", 64'(out_valid), 64'd0);
    chk("rst_pend", 64'(pend_cnt), 64'd0);
    chk("rst_pc", 64'(out_pc), 64'd0);
    chk("rst_error", 64'(error), 64'd0);
    tick(); tick();
    rst = 1'b0;
    #1;
    chk("allow_after_rst", 64'(allow), 64'd1);

    // single fetch
    fire = 1'b1; req = 1'b1; pc = 32'h1C00_0004;
    tick();
    fire = 1'b0;
    chk("t1_pend", 64'(pend_cnt), 64'd1);
    chk("t1_no_early", 64'(out_valid), 64'd0);
    data_ok = 1'b1; rdata = {32'h22, 32'h11};
    tick();
    data_ok = 1'b0;
    chk("t1_valid", 64'(out_valid), 64'd1);
    chk("t1_pc", 64'(out_pc), 64'h1C00_0004);
    chk("t1_mask", 64'(out_mask), 64'b10);
    chk("t1_inst", out_inst, 64'h0000_0022_0000_0011);
    chk("t1_excode", 64'(out_excode), 64'd0);
    chk("t1_pend_done", 64'(pend_cnt), 64'd0);
    tick();
    chk("t1_popped", 64'(out_valid), 64'd0);

    // flush with two in flight
    fire = 1'b1; req = 1'b1; pc = 32'h1C00_0010;
    tick();
    pc = 32'h1C00_0018;
    tick();
    fire = 1'b0;
    chk("t2_allow_credits", 64'(allow), 64'd0);
    flush = 1'b1;
    #1;
    chk("t2_allow_flush", 64'(allow), 64'd0);
    tick();
    flush = 1'b0;
    chk("t2_cc", 64'(pend_cnt), 64'd2);
    chk("t2_valid_after_flush", 64'(out_valid), 64'd0);
    #1;
    chk("t2_allow_cc_full", 64'(allow), 64'd0);
    data_ok = 1'b1; rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    tick();
    chk("t2_drop1_valid", 64'(out_valid), 64'd0);
    chk("t2_drop1_cc", 64'(pend_cnt), 64'd1);
    tick();
    data_ok = 1'b0;
    chk("t2_drop2_valid", 64'(out_valid), 64'd0);
    chk("t2_drop2_cc", 64'(pend_cnt), 64'd0);
    #1;
    chk("t2_allow_back", 64'(allow), 64'd1);
    fire = 1'b1; req = 1'b1; pc = 32'h1C00_0100;
    tick();
    fire = 1'b0; data_ok = 1'b1; rdata = {32'hBBBB, 32'hAAAA};
    tick();
    data_ok = 1'b0;
    chk("t2_new_valid", 64'(out_valid), 64'd1);
    chk("t2_new_pc", 64'(out_pc), 64'h1C00_0100);
    chk("t2_new_mask", 64'(out_mask), 64'b11);
    chk("t2_new_inst", out_inst, 64'h0000_BBBB_0000_AAAA);
    tick();

    // flush with coincident data_ok
    fire = 1'b1; req = 1'b1; pc = 32'h1C00_0020;
    tick();
    pc = 32'h1C00_0028;
    tick();
    fire = 1'b0; flush = 1'b1; data_ok = 1'b1;
    tick();
    flush = 1'b0;
    chk("t3_cc", 64'(pend_cnt), 64'd1);
    chk("t3_valid", 64'(out_valid), 64'd0);
    tick();
    data_ok = 1'b0;
    chk("t3_drop_valid", 64'(out_valid), 64'd0);
    chk("t3_cc_zero", 64'(pend_cnt), 64'd0);

    // backpressure
    ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      fire = 1'b1; req = 1'b1; pc = 32'h1C00_0200 + 32'(i * 16);
      tick();
      fire = 1'b0; data_ok = 1'b1; rdata = {32'(i) + 32'h100, 32'(i)};
      tick();
      data_ok = 1'b0;
      if (i == 2) chk("t4_allow_q3", 64'(allow), 64'd1);
    end
    #1;
    chk("t4_allow_full", 64'(allow), 64'd0);
    chk("t4_valid", 64'(out_valid), 64'd1);
    chk("t4_head_pc", 64'(out_pc), 64'h1C00_0200);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    chk("t4_allow_restored", 64'(allow), 64'd1);
    chk("t4_next_pc", 64'(out_pc), 64'h1C00_0210);
    chk("t4_next_inst", out_inst, 64'h0000_0101_0000_0001);
    ready = 1'b1;
    tick(); tick(); tick();
    chk("t4_drained", 64'(out_valid), 64'd0);

    // exception-only fetch behind a pending request
    ready = 1'b0;
    fire = 1'b1; req = 1'b1; pc = 32'h1C00_0300; excode = 6'h00;
    tick();
    req = 1'b0; pc = 32'h1C00_0308; excode = 6'h08;
    tick();
    fire = 1'b0; excode = 6'h00;
    chk("t5_pend", 64'(pend_cnt), 64'd2);
    chk("t5_wait", 64'(out_valid), 64'd0);
    data_ok = 1'b1; rdata = {32'h44, 32'h33};
    tick();
    data_ok = 1'b0;
    chk("t5_req_pc", 64'(out_pc), 64'h1C00_0300);
    chk("t5_req_inst", out_inst, 64'h0000_0044_0000_0033);
    chk("t5_req_excode", 64'(out_excode), 64'd0);
    tick();
    chk("t5_exc_moved", 64'(pend_cnt), 64'd0);
    ready = 1'b1;
    tick();
    chk("t5_exc_valid", 64'(out_valid), 64'd1);
    chk("t5_exc_pc", 64'(out_pc), 64'h1C00_0308);
    chk("t5_exc_excode", 64'(out_excode), 64'h08);
    chk("t5_exc_inst", out_inst, 64'd0);
    tick();
    chk("t5_drained", 64'(out_valid), 64'd0);

    // exception-only fetch with nothing pending appears next cycle
    ready = 1'b0;
    fire = 1'b1; req = 1'b0; pc = 32'h1C00_0404; excode = 6'h0C;
    tick();
    fire = 1'b0; excode = 6'h00;
    chk("t6_valid", 64'(out_valid), 64'd1);
    chk("t6_pc", 64'(out_pc), 64'h1C00_0404);
    chk("t6_excode", 64'(out_excode), 64'h0C);
    chk("t6_mask", 64'(out_mask), 64'b10);
    chk("t6_inst", out_inst, 64'd0);
    ready = 1'b1;
    tick();
    chk("t6_drained", 64'(out_valid), 64'd0);

    // spurious response
    chk("t7_error_before", 64'(error), 64'd0);
    data_ok = 1'b1; rdata = 64'h1234;
    tick();
    data_ok = 1'b0;
    chk("t7_dropped", 64'(out_valid), 64'd0);
    chk("t7_pend", 64'(pend_cnt), 64'd0);
    chk("t7_error", 64'(error), 64'(ERR_EXP));
    tick(); tick();
    chk("t7_error_sticky", 64'(error), 64'(ERR_EXP));
    rst = 1'b1;
    #1;
    chk("t7_error_rst", 64'(error), 64'd0);
    tick();
    rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ift_resp_queue.md
# ift_resp_queue

Parametrised successor to the IF-T fetch-response stage. It sits between pre-IF/i-cache request issue and the decode-side instruction queue. It tracks every fetch issued to the i-cache in order, matches each `data_ok` to its fetch PC, and discards responses belonging to flushed fetches using a cancel counter. Surviving fetch groups are buffered in a QDEPTH-entry queue with valid/ready backpressure, and credit-based issue throttling guarantees that a response never arrives to a full queue.

## Interface
Parameters:
- FETCH_W, 2: instructions per fetch group; power of two, 1..8.
- MAX_OUT, 2: maximum fetches in flight in the i-cache, cancelled ones included.
- QDEPTH, 4: output queue entries; must be ≥ MAX_OUT.
- PC_W, 32: PC width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- flush_i  in  1  exception or branch redirect; kills all fetches not yet delivered.
- fetch_fire_i  in  1  pre-IF commits one fetch this cycle.
- fetch_req_i  in  1  1 = an i-cache request was sent; 0 = exception-only fetch, which waits for no data.
- fetch_pc_i  in  PC_W  fetch PC.
- fetch_excode_i  in  6  exception code; 0 = none.
- fetch_allow_o  out  1  pre-IF may fire this cycle.
- icache_data_ok_i  in  1  response valid.
- icache_rdata_i  in  32*FETCH_W  response data; lane k in bits [32k+31:32k].
- out_valid_o  out  1  queue head valid.
- out_ready_i  in  1  consumer accepts the head.
- out_pc_o  out  PC_W  head group PC.
- out_inst_o  out  32*FETCH_W  head instructions; zero for exception-only groups.
- out_mask_o  out  FETCH_W  lane k set iff k ≥ pc[log2(FETCH_W)+1:2].
- out_excode_o  out  6  head exception code.
- pend_cnt_o  out  $clog2(MAX_OUT+1)  live pending plus cancelled fetches.
- error_o  out  1  sticky protocol error; present only with the check macro.

## Operation
- **Pending FIFO** (MAX_OUT entries of {pc, req, excode}): pushed on fetch_fire_i.
- **Cancel counter** (cc, range 0..MAX_OUT).
- **Output queue**: QDEPTH entries.
- **data_ok handling**:
  - If cc > 0: cc decrements and the data is dropped.
  - Otherwise the pending head (req = 1) is popped and {pc, rdata, mask, excode} is pushed to the queue.
- **Exception-only head** (req = 0) with cc = 0: popped to the queue without data, at most one per cycle. It is ordered behind earlier requests.
- **Flush**:
  - cc_next = cc + (live req = 1 pending entries, counting a coincident fire) − (coincident data_ok).
  - The pending FIFO and the output queue are cleared.
  - A fetch_fire_i in the flush cycle belongs to the old stream and is cancelled.
- **Credits**: fetch_allow_o = !flush_i && (pend_live + cc < MAX_OUT) && (pend_live + q_count < QDEPTH).
- **Queue pop**: on out_valid_o && out_ready_i.
- **Simultaneous events**: push and pop in the same cycle are both applied.

## Timing
- **Reset**: all outputs 0; cc = 0; FIFO and queue empty.
- **Latency**: a data_ok accepted in cycle t is visible at out_* in cycle t+1. There is no combinational path from icache to out.
- **Exception-only fetch**: fire at t appears at out at t+1 earliest, when no requests are pending.
- **Flush**: out_valid_o is 0 in cycle t+1. fetch_allow_o is low during the flush cycle and recovers the next cycle if credits permit.
- **Reset mid-operation**: an in-flight cache response arriving after reset is counted as an error (with the check macro) and dropped.

## Configuration
- `IFT_RESP_CHECK_EN` defined: error_o is set sticky, cleared only by rst, on any of:
  - data_ok with cc = 0 and the pending head absent or req = 0;
  - a fire while fetch_allow_o = 0;
  - cc overflow;
  - queue push while full.
- Not defined: error_o tied 0 and the checker logic is absent.

## Structure
- Shared package `ift_pkg`:
  - pending-entry struct {pc, req, excode};
  - queue-entry struct;
  - excode width constant (6);
  - the mask-generation function.
- One sub-module: `ift_sync_fifo`, a parametrised width/depth FIFO with clear. It is instantiated for both the pending FIFO and the output queue.

## Test plan
- **Single fetch**: pc 0x1C000004, FETCH_W = 2, data_ok next cycle with 0x11/0x22 -> out_pc 0x1C000004, mask 2'b10, inst {0x22,0x11}.
- **Flush with two in flight**: flush with 2 outstanding -> cc = 2; the next two data_ok are dropped and out_valid_o stays 0; a fetch at 0x1C000100 then delivers normally.
- **Flush with coincident data_ok**: 2 outstanding, data_ok in the flush cycle -> cc = 1.
- **Backpressure**: out_ready_i = 0 with QDEPTH = 4 -> after 4 queued groups fetch_allow_o = 0; one pop restores it next cycle.
- **Exception ordering**: exception-only fetch (excode 0x08) behind a pending request -> delivered after the request's group, in order, inst = 0.
- **Spurious response**: data_ok with nothing pending and `IFT_RESP_CHECK_EN` defined -> error_o = 1 and stays 1 until rst.
